cbfp_2: RTL and testbench
=========================

// Module: cbfp_2
// PURPOSE
//  Convergent block-floating-point normaliser on the output side of FFT stage 2.
//  Receives 16-lane complex beats with CBFP_valid, 4 beats per block (64 complex samples).
//  Finds the block-wide minimum of redundant sign bits over all re and im values.
//  Left-shifts every sample by that amount and emits 13-bit samples, with the shift as the block exponent.
//  Ping-pong buffered: accepts back-to-back blocks with no stall.
// PARAMETERS
//  WIDTH_IN   16  input sample width, <10.6> signed
//  WIDTH_OUT  13  output sample width, signed
//  LANES      16  complex samples per beat
//  BLK_BEATS  4   beats per CBFP block; power of two
// PORTS
//  clk             in   1                       system clock, rising edge
//  rstn            in   1                       asynchronous active-low reset
//  cbfp_in_re      in   WIDTH_IN  x LANES       real input samples [0:LANES-1]
//  cbfp_in_im      in   WIDTH_IN  x LANES       imaginary input samples [0:LANES-1]
//  CBFP_valid      in   1                       input beat valid
//  cbfp_out_re     out  WIDTH_OUT x LANES       normalised real output samples
//  cbfp_out_im     out  WIDTH_OUT x LANES       normalised imaginary output samples
//  cbfp_out_valid  out  1                       output beat valid
//  cbfp_exp        out  5                       block shift s; stable for all beats of the block
//  cbfp_beat       out  $clog2(BLK_BEATS)       index of the output beat within its block
// BEHAVIOUR
//  Reset: all outputs 0; beat counters, bank select and running minimum cleared.
//  Any partially captured block is discarded.
//  Redundant sign count lsc(x):
//    - number of consecutive bits below the MSB equal to the MSB, range 0..WIDTH_IN-1
//    - lsc(0) = lsc(-1) = 15
//  Input side:
//    - Each beat with CBFP_valid=1 is written into the current write bank at index wr_cnt.
//    - running_min <= min(running_min, lsc of all 2*LANES values); running_min is reloaded at beat 0.
//    - No ready signal exists; the block is always ready.
//    - Gaps (CBFP_valid=0) between beats of a block are allowed; counters hold during gaps.
//  Block close:
//    - On the edge capturing beat BLK_BEATS-1, the block's final min is latched as s for that bank.
//    - The banks swap, and wr_cnt wraps to 0.
//  Output side:
//    - Starting the next edge, the bank is read out in BLK_BEATS consecutive cycles, beats 0..3 in order.
//    - cbfp_out_valid=1 during readout; cbfp_beat = read index; cbfp_exp = s.
//    - Output beat j is registered on edge (close_edge + 1 + j).
//    - With contiguous input, per-beat latency is BLK_BEATS edges.
//  No overflow: a new block needs >= BLK_BEATS edges to fill, so readout of the other bank always finishes first.
//  Back-to-back blocks therefore give uninterrupted cbfp_out_valid.
//  Arithmetic:
//    - y = x <<< s in WIDTH_IN bits; this is lossless because s <= lsc(x) for every sample.
//    - out = y[WIDTH_IN-1 -: WIDTH_OUT], truncation toward minus infinity, no rounding.
//    - Saturation is never needed.
//  Between readouts: cbfp_out_valid=0; data, exponent and beat outputs hold their last values.
//  Reset mid-operation (rstn low at any cycle):
//    - outputs go to 0 immediately;
//    - after release, the first accepted beat is treated as beat 0 of a new block.
// TESTING
//  1. All-zero block, 4 contiguous beats -> 4 output beats of 0, cbfp_exp=15, cbfp_beat 0..3.
//  2. One re=0x7FFF, others 0x0001 -> s=0; 0x7FFF outputs 0x0FFF, 0x0001 outputs 0x0000.
//  3. Block max |x|: re=255 and im=-256, others 0 -> s=7;
//     255 outputs 0x0FF0, -256 outputs 0x1000 (-4096).
//  4. 8 contiguous beats forming blocks with s=2 then s=5 -> cbfp_out_valid high 8 consecutive cycles;
//     exp is 2 for beats 0-3 and 5 for beats 4-7; first output 5 edges after first input.
//  5. Beats spaced 3 cycles apart -> no output until the 4th beat is captured,
//     then 4 consecutive valid beats starting the next edge.
//  6. Reset asserted after 2 beats of a block, then a full block sent -> no output from the partial block;
//     the new block is output correctly with its own exponent.

Source files
------------

// File: rtl/cbfp_2.sv
// Convergent block-floating-point normaliser after FFT stage 2: finds the block-wide
// minimum redundant-sign count over 64 complex samples and emits them left-aligned to 13 bits.
module cbfp_2 #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 13,
  parameter int LANES     = 16,
  parameter int BLK_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [WIDTH_IN-1:0]  cbfp_in_re [0:LANES-1],
  input  logic signed [WIDTH_IN-1:0]  cbfp_in_im [0:LANES-1],
  input  logic                        CBFP_valid,
  output logic signed [WIDTH_OUT-1:0] cbfp_out_re [0:LANES-1],
  output logic signed [WIDTH_OUT-1:0] cbfp_out_im [0:LANES-1],
  output logic                        cbfp_out_valid,
  output logic [4:0]                  cbfp_exp,
  output logic [((BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1)-1:0] cbfp_beat
);

  localparam int BW = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLK_BEATS - 1);
  localparam logic [4:0]    LSC_MAX   = 5'(WIDTH_IN - 1);

  function automatic logic [4:0] lsc(input logic signed [WIDTH_IN-1:0] x);
    logic [4:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = WIDTH_IN - 2; i >= 0; i--) begin
      if (run && (x[i] == x[WIDTH_IN-1])) n = n + 5'd1;
      else                                run = 1'b0;
    end
    return n;
  endfunction

  // Lossless because s never exceeds the sample's own sign redundancy; the
  // arithmetic right shift keeps the top WIDTH_OUT bits (floor truncation).
  function automatic logic signed [WIDTH_OUT-1:0] normalise(
    input logic signed [WIDTH_IN-1:0] x,
    input logic [4:0]                 s
  );
    logic signed [WIDTH_IN-1:0] y;
    y = x <<< s;
    y = y >>> (WIDTH_IN - WIDTH_OUT);
    return WIDTH_OUT'(y);
  endfunction

  logic [BW-1:0]  r_wr_cnt;
  logic           r_wr_bank;
  logic [4:0]     r_run_min;
  logic           r_rd_act;
  logic [BW-1:0]  r_rd_cnt;
  logic           r_rd_bank;
  logic [4:0]     r_rd_exp;

  logic signed [WIDTH_IN-1:0] r_mem_re [0:2*BLK_BEATS-1][0:LANES-1];
  logic signed [WIDTH_IN-1:0] r_mem_im [0:2*BLK_BEATS-1][0:LANES-1];

  logic [4:0]     w_beat_min;
  logic [4:0]     w_blk_min;
  logic           w_close;
  logic [BW:0]    w_wr_addr;
  logic [BW:0]    w_rd_addr;

  always_comb begin
    w_beat_min = LSC_MAX;
    for (int l = 0; l < LANES; l++) begin
      if (lsc(cbfp_in_re[l]) < w_beat_min) w_beat_min = lsc(cbfp_in_re[l]);
      if (lsc(cbfp_in_im[l]) < w_beat_min) w_beat_min = lsc(cbfp_in_im[l]);
    end
  end

  // Beat 0 reloads the running minimum instead of merging with the previous block.
  assign w_blk_min = (r_wr_cnt == '0)        ? w_beat_min :
                     (r_run_min < w_beat_min) ? r_run_min  : w_beat_min;
  assign w_close   = CBFP_valid && (r_wr_cnt == LAST_BEAT);
  assign w_wr_addr = {r_wr_bank, r_wr_cnt};
  assign w_rd_addr = {r_rd_bank, r_rd_cnt};

  // Stage p0: capture beat into the write bank
  always_ff @(posedge clk) begin
    if (CBFP_valid) begin
      for (int l = 0; l < LANES; l++) begin
        r_mem_re[w_wr_addr][l] <= cbfp_in_re[l];
        r_mem_im[w_wr_addr][l] <= cbfp_in_im[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_run_min <= '0;
      r_rd_act  <= 1'b0;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_rd_exp  <= '0;
    end else begin
      if (CBFP_valid) begin
        r_wr_cnt  <= (r_wr_cnt == LAST_BEAT) ? '0 : r_wr_cnt + 1'b1;
        r_run_min <= w_blk_min;
      end
      if (r_rd_act) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        if (r_rd_cnt == LAST_BEAT) r_rd_act <= 1'b0;
      end
      // A closing block always lands on or after the last readout edge of the other bank.
      if (w_close) begin
        r_wr_bank <= ~r_wr_bank;
        r_rd_act  <= 1'b1;
        r_rd_cnt  <= '0;
        r_rd_bank <= r_wr_bank;
        r_rd_exp  <= w_blk_min;
      end
    end
  end

  // Stage p1: normalised readout registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cbfp_out_valid <= 1'b0;
      cbfp_exp       <= '0;
      cbfp_beat      <= '0;
      for (int l = 0; l < LANES; l++) begin
        cbfp_out_re[l] <= '0;
        cbfp_out_im[l] <= '0;
      end
    end else begin
      cbfp_out_valid <= r_rd_act;
      if (r_rd_act) begin
        cbfp_exp  <= r_rd_exp;
        cbfp_beat <= r_rd_cnt;
        for (int l = 0; l < LANES; l++) begin
          cbfp_out_re[l] <= normalise(r_mem_re[w_rd_addr][l], r_rd_exp);
          cbfp_out_im[l] <= normalise(r_mem_im[w_rd_addr][l], r_rd_exp);
        end
      end
    end
  end

endmodule

// File: tb/tb_cbfp_2.sv
// Directed bench for cbfp_2: table of single-block vectors plus hand-written
// back-to-back, gapped and mid-block reset sequences.
module tb_cbfp_2;

  logic               clk;
  logic               rstn;
  logic signed [15:0] cbfp_in_re [0:15];
  logic signed [15:0] cbfp_in_im [0:15];
  logic               CBFP_valid;
  logic signed [12:0] cbfp_out_re [0:15];
  logic signed [12:0] cbfp_out_im [0:15];
  logic               cbfp_out_valid;
  logic [4:0]         cbfp_exp;
  logic [1:0]         cbfp_beat;

  cbfp_2 dut (
    .clk(clk), .rstn(rstn),
    .cbfp_in_re(cbfp_in_re), .cbfp_in_im(cbfp_in_im), .CBFP_valid(CBFP_valid),
    .cbfp_out_re(cbfp_out_re), .cbfp_out_im(cbfp_out_im),
    .cbfp_out_valid(cbfp_out_valid), .cbfp_exp(cbfp_exp), .cbfp_beat(cbfp_beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] bg_re, bg_im, sp_re, sp_im;
    int          sp_beat, sp_lane;
    int          s;
    logic [12:0] o_bg_re, o_bg_im, o_sp_re, o_sp_im;
  } vec_t;

  vec_t        vecs [0:4];
  int          total = 0;
  int          bad   = 0;
  logic [12:0] er [0:15];
  logic [12:0] ei [0:15];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_lanes(input string nm);
    int first;
    first = -1;
    for (int l = 0; l < 16; l++)
      if (first < 0 && (cbfp_out_re[l] !== er[l] || cbfp_out_im[l] !== ei[l])) first = l;
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s lane %0d: got re=%h im=%h expected re=%h im=%h", nm, first,
               cbfp_out_re[first], cbfp_out_im[first], er[first], ei[first]);
    end
  endtask

  task automatic set_uniform(input logic [15:0] re, input logic [15:0] im, input logic v);
    for (int l = 0; l < 16; l++) begin
      cbfp_in_re[l] = re;
      cbfp_in_im[l] = im;
    end
    CBFP_valid = v;
  endtask

  task automatic set_exp_uniform(input logic [12:0] v);
    for (int l = 0; l < 16; l++) begin
      er[l] = v;
      ei[l] = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"zero",   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,  15,
                13'h0000, 13'h0000, 13'h0000, 13'h0000};
    vecs[1] = '{"maxpos", 16'h0001, 16'h0001, 16'h7FFF, 16'h0001, 2, 5,  0,
                13'h0000, 13'h0000, 13'h0FFF, 13'h0000};
    vecs[2] = '{"s7",     16'h0000, 16'h0000, 16'h00FF, 16'hFF00, 3, 15, 7,
                13'h0000, 13'h0000, 13'h0FF0, 13'h1000};
    vecs[3] = '{"neg1",   16'hFFFF, 16'hFFFF, 16'h0123, 16'hFFFD, 1, 7,  6,
                13'h1FF8, 13'h1FF8, 13'h0918, 13'h1FE8};
    vecs[4] = '{"floor",  16'h0040, 16'h0040, 16'hC000, 16'hFFFB, 0, 3,  1,
                13'h0010, 13'h0010, 13'h1000, 13'h1FFE};

    rstn = 1'b0;
    set_uniform(16'h0, 16'h0, 1'b0);
    tick();
    tick();
    chk("rst_valid", int'(cbfp_out_valid), 0);
    chk("rst_exp",   int'(cbfp_exp), 0);
    chk("rst_beat",  int'(cbfp_beat), 0);
    set_exp_uniform(13'h0);
    chk_lanes("rst_data");
    rstn = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < 4; b++) begin
        set_uniform(vecs[v].bg_re, vecs[v].bg_im, 1'b1);
        if (b == vecs[v].sp_beat) begin
          cbfp_in_re[vecs[v].sp_lane] = vecs[v].sp_re;
          cbfp_in_im[vecs[v].sp_lane] = vecs[v].sp_im;
        end
        tick();
      end
      set_uniform(16'h0, 16'h0, 1'b0);
      for (int j = 0; j < 4; j++) begin
        tick();
        set_exp_uniform(vecs[v].o_bg_re);
        for (int l = 0; l < 16; l++) ei[l] = vecs[v].o_bg_im;
        if (j == vecs[v].sp_beat) begin
          er[vecs[v].sp_lane] = vecs[v].o_sp_re;
          ei[vecs[v].sp_lane] = vecs[v].o_sp_im;
        end
        chk({vecs[v].name, "_valid"}, int'(cbfp_out_valid), 1);
        chk({vecs[v].name, "_beat"},  int'(cbfp_beat), j);
        chk({vecs[v].name, "_exp"},   int'(cbfp_exp), vecs[v].s);
        chk_lanes({vecs[v].name, "_data"});
      end
      tick();
      chk({vecs[v].name, "_idle_valid"}, int'(cbfp_out_valid), 0);
      chk({vecs[v].name, "_hold_exp"},   int'(cbfp_exp), vecs[v].s);
      chk({vecs[v].name, "_hold_beat"},  int'(cbfp_beat), 3);
    end

    // Two contiguous blocks: s=2 (0x1000) then s=5 (0x0200); both normalise to 0x800.
    set_exp_uniform(13'h0800);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 4)      set_uniform(16'h1000, 16'h1000, 1'b1);
      else if (c <= 8) set_uniform(16'h0200, 16'h0200, 1'b1);
      else             set_uniform(16'h0, 16'h0, 1'b0);
      tick();
      chk($sformatf("b2b_valid_c%0d", c), int'(cbfp_out_valid), (c >= 5) ? 1 : 0);
      if (c >= 5) begin
        chk($sformatf("b2b_beat_c%0d", c), int'(cbfp_beat), (c - 5) % 4);
        chk($sformatf("b2b_exp_c%0d", c),  int'(cbfp_exp), (c <= 8) ? 2 : 5);
        chk_lanes($sformatf("b2b_data_c%0d", c));
      end
    end
    tick();
    chk("b2b_end_valid", int'(cbfp_out_valid), 0);

    // Beats every third cycle; idle cycles carry a large value that must be ignored.
    for (int t = 0; t <= 14; t++) begin
      if (t % 3 == 0 && t <= 9) set_uniform(16'h0001, 16'h0001, 1'b1);
      else                      set_uniform(16'h7FFF, 16'h7FFF, 1'b0);
      tick();
      chk($sformatf("gap_valid_t%0d", t), int'(cbfp_out_valid), (t >= 10 && t <= 13) ? 1 : 0);
      if (t >= 10 && t <= 13) begin
        chk($sformatf("gap_beat_t%0d", t), int'(cbfp_beat), t - 10);
        chk($sformatf("gap_exp_t%0d", t),  int'(cbfp_exp), 14);
        chk_lanes($sformatf("gap_data_t%0d", t));
      end
    end
    set_uniform(16'h0, 16'h0, 1'b0);

    // Partial block, then asynchronous reset, then a full fresh block.
    for (int b = 0; b < 2; b++) begin
      set_uniform(16'h7FFF, 16'h7FFF, 1'b1);
      tick();
    end
    set_uniform(16'h0, 16'h0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_valid", int'(cbfp_out_valid), 0);
    chk("midrst_exp",   int'(cbfp_exp), 0);
    chk("midrst_beat",  int'(cbfp_beat), 0);
    set_exp_uniform(13'h0);
    chk_lanes("midrst_data");
    tick();
    rstn = 1'b1;
    tick();
    set_exp_uniform(13'h0800);
    for (int b = 0; b < 4; b++) begin
      set_uniform(16'h0010, 16'h0010, 1'b1);
      tick();
      chk($sformatf("post_rst_fill_valid_b%0d", b), int'(cbfp_out_valid), 0);
    end
    set_uniform(16'h0, 16'h0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("post_rst_valid_j%0d", j), int'(cbfp_out_valid), 1);
      chk($sformatf("post_rst_beat_j%0d", j),  int'(cbfp_beat), j);
      chk($sformatf("post_rst_exp_j%0d", j),   int'(cbfp_exp), 10);
      chk_lanes($sformatf("post_rst_data_j%0d", j));
    end
    tick();
    chk("post_rst_end_valid", int'(cbfp_out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
